saph_col_unpack_stream: RTL and testbench

//   Streaming pixel unpacker: accepts DATA_W-bit words holding 2^bpp_log-bit packed pixels (LSB first),

---
 rtl/saph_col_unpack_stream_if.sv | 37 +++
 rtl/saph_col_unpack_stream.sv | 82 ++++++++
 tb/tb_saph_col_unpack_stream.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/saph_col_unpack_stream_if.sv
// saph_col_unpack_stream_if: pixel format types and the packed-word in / colour out stream bundle
package saph_col_pkg;
  typedef struct packed {
    logic [4:0] pos;
    logic [2:0] w;
  } chan_t;
  typedef struct packed {
    logic [2:0] cat;
    chan_t      a;
    chan_t      r;
    chan_t      g;
    chan_t      b;
  } pixfmt_t;
  localparam logic [2:0] CAT_ARGB = 3'd0;
  localparam logic [2:0] CAT_RGB  = 3'd1;
  localparam logic [2:0] CAT_GREY = 3'd2;
  localparam logic [2:0] CAT_PAL  = 3'd3;
endpackage

interface saph_col_unpack_stream_if #(parameter int DATA_W = 32);
  import saph_col_pkg::*;
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic [$clog2(DATA_W):0] in_count;
  pixfmt_t                 in_fmt;
  logic [2:0]              in_bpp_log;
  logic                    out_valid;
  logic                    out_ready;
  logic [31:0]             out_col;
  logic                    out_last;
  logic                    err;
  modport master (output in_valid, in_data, in_count, in_fmt, in_bpp_log, out_ready,
                  input in_ready, out_valid, out_col, out_last, err);
  modport slave (input in_valid, in_data, in_count, in_fmt, in_bpp_log, out_ready,
                 output in_ready, out_valid, out_col, out_last, err);
endinterface

// File: rtl/saph_col_unpack_stream.sv
// saph_col_unpack_stream: streams packed pixel words out as one ARGB8888 colour per cycle
module saph_col_unpack_stream
  import saph_col_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter bit REPLICATE = 1
) (
  input logic clk,
  input logic rst,
  saph_col_unpack_stream_if.slave bus
);
  localparam int CW = $clog2(DATA_W) + 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] word;
  pixfmt_t fmt;
  logic [2:0] bpp;
  logic [CW-1:0] idx, cnt, ppw, eff;
  logic load, last_load, acc, legal, valid_q, last_q, err_q;
  logic [31:0] col_q, pix, col_n;
  function automatic logic [7:0] chan(input logic [31:0] p, input chan_t c);
    logic [3:0] n;
    logic [7:0] v, a, r;
    logic [15:0] t;
    n = {1'b0, c.w} + 4'd1;
    t = 16'(p >> c.pos);
    v = t[7:0] & 8'((9'd1 << n) - 9'd1);
    a = v << (4'd8 - n);
    r = a;
    for (int i = 1; i < 8; i++) begin
      t = {a, 8'h00} >> (i * int'(n));
      r = r | t[15:8];
    end
    return REPLICATE ? r : a;
  endfunction
  // handshake, word sizing, pixel select and colour unpack
  always_comb begin
    load = state == BUSY && (!valid_q || bus.out_ready);
    last_load = load && idx == cnt - CW'(1);
    acc = bus.in_valid && (state == IDLE || last_load);
    legal = bus.in_bpp_log <= 3'd5 && int'(bus.in_bpp_log) <= $clog2(DATA_W);
    ppw = CW'(DATA_W >> bus.in_bpp_log);
    eff = (bus.in_count == '0 || bus.in_count > ppw) ? ppw : bus.in_count;
    pix = 32'(word >> (32'(idx) << bpp)) & ((32'd1 << (32'd1 << bpp)) - 32'd1);
    col_n = fmt.cat == CAT_ARGB ? {chan(pix, fmt.a), chan(pix, fmt.r), chan(pix, fmt.g), chan(pix, fmt.b)} :
            fmt.cat == CAT_RGB  ? {8'hFF, chan(pix, fmt.r), chan(pix, fmt.g), chan(pix, fmt.b)} :
            fmt.cat == CAT_GREY ? {8'hFF, {3{chan(pix, fmt.b)}}} :
            fmt.cat == CAT_PAL  ? pix : 32'd0;
    state_n = acc ? (legal ? BUSY : IDLE) : last_load ? IDLE : state;
  end
  // hold register occupancy
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // hold register capture and registered output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      col_q <= '0;
      last_q <= 1'b0;
      err_q <= 1'b0;
      idx <= '0;
    end else begin
      err_q <= acc && !legal;
      if (acc) begin
        word <= bus.in_data;
        fmt <= bus.in_fmt;
        bpp <= bus.in_bpp_log;
        cnt <= eff;
        idx <= '0;
      end else if (load) idx <= idx + CW'(1);
      if (load) begin
        col_q <= col_n;
        last_q <= idx == cnt - CW'(1);
        valid_q <= 1'b1;
      end else if (bus.out_ready) valid_q <= 1'b0;
    end
  end
  assign bus.in_ready = state == IDLE || last_load;
  assign bus.out_valid = valid_q;
  assign bus.out_col = col_q;
  assign bus.out_last = last_q;
  assign bus.err = err_q;
endmodule

// File: tb/tb_saph_col_unpack_stream.sv
// tb_saph_col_unpack_stream: directed vectors with a queue scoreboard and decoupled output monitor
module tb_saph_col_unpack_stream;
  import saph_col_pkg::*;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  saph_col_unpack_stream_if #(.DATA_W(32)) bus ();
  saph_col_unpack_stream_if #(.DATA_W(32)) bus0 ();
  saph_col_unpack_stream #(.DATA_W(32), .REPLICATE(1)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  saph_col_unpack_stream #(.DATA_W(32), .REPLICATE(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  int checks = 0, failures = 0, err_seen = 0, cyc = 0, acc_cyc = 0;
  logic [32:0] expq[$];
  int popc[$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask
  function automatic chan_t ch(input int pos, input int w);
    return '{pos: 5'(pos), w: 3'(w)};
  endfunction
  function automatic pixfmt_t fm(input logic [2:0] cat, input chan_t a, input chan_t r, input chan_t g, input chan_t b);
    return '{cat: cat, a: a, r: r, g: g, b: b};
  endfunction
  pixfmt_t rgb565, grey1, argb, pal;
  task automatic exp(input logic [31:0] col, input bit last);
    expq.push_back({last, col});
  endtask
  task automatic send(input logic [31:0] d, input logic [5:0] c, input pixfmt_t f, input logic [2:0] b, output int waited);
    bus.in_valid = 1;
    bus.in_data = d;
    bus.in_count = c;
    bus.in_fmt = f;
    bus.in_bpp_log = b;
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 200) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end
    acc_cyc = cyc;
    @(posedge clk);
    #1 bus.in_valid = 0;
  endtask
  task automatic drain(input string name);
    int t = 0;
    while (expq.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk(name, 64'(expq.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    logic [32:0] e;
    if (bus.err) err_seen++;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out: got %h expected no pixel", bus.out_col);
      end else begin
        e = expq.pop_front();
        chk("out_pixel", 64'({bus.out_last, bus.out_col}), 64'(e));
        popc.push_back(cyc);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int w, wsum, e0, t;
    logic [31:0] aw[4];
    aw = '{32'h11223344, 32'h8899AABB, 32'hDEADBEEF, 32'h01020304};
    rgb565 = fm(CAT_RGB, ch(0, 0), ch(11, 4), ch(5, 5), ch(0, 4));
    grey1 = fm(CAT_GREY, ch(0, 0), ch(0, 0), ch(0, 0), ch(0, 0));
    argb = fm(CAT_ARGB, ch(24, 7), ch(16, 7), ch(8, 7), ch(0, 7));
    pal = fm(CAT_PAL, ch(0, 0), ch(0, 0), ch(0, 0), ch(0, 0));
    bus.in_valid = 0; bus.in_data = 0; bus.in_count = 0; bus.in_fmt = '0; bus.in_bpp_log = 0; bus.out_ready = 1;
    bus0.in_valid = 0; bus0.in_data = 0; bus0.in_count = 0; bus0.in_fmt = '0; bus0.in_bpp_log = 0; bus0.out_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_out_col", 64'({bus.out_last, bus.out_col}), 64'd0);
    chk("reset_err", 64'(bus.err), 64'd0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    exp(32'hFF00FF00, 0); exp(32'hFFFF0000, 1);
    send(32'hF800_07E0, 0, rgb565, 4, w);
    drain("rgb565_drain");
    chk("latency", 64'(popc[popc.size()-2] - acc_cyc), 64'd2);
    exp(32'hFFFFFFFF, 0); exp(32'hFF000000, 0); exp(32'hFFFFFFFF, 0); exp(32'hFF000000, 1);
    send(32'h5, 4, grey1, 0, w);
    drain("grey_drain");
    exp(32'hFFFFFFFF, 1);
    send(32'h0000FFFF, 1, rgb565, 4, w);
    drain("rep1_drain");
    exp(32'hFF00FF00, 0); exp(32'hFFFF0000, 1);
    send(32'hF800_07E0, 7, rgb565, 4, w);
    drain("clamp_drain");
    exp(32'h5A, 0); exp(32'hA5, 1);
    send(32'h0000A55A, 2, pal, 3, w);
    drain("pal_drain");
    exp(32'h11, 0); exp(32'h22, 0); exp(32'h33, 0); exp(32'h44, 1);
    send(32'h44332211, 0, pal, 3, w);
    t = 0;
    @(negedge clk);
    while (!bus.out_valid && t < 20) begin
      t++;
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_col", 64'({bus.out_last, bus.out_col}), 64'h22);
      chk("stall_valid", 64'(bus.out_valid), 64'd1);
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1;
    drain("stall_drain");
    wsum = 0;
    foreach (aw[i]) exp(aw[i], 1);
    foreach (aw[i]) begin
      send(aw[i], 0, argb, 5, w);
      wsum += w;
    end
    drain("b2b_drain");
    chk("b2b_in_ready", 64'(wsum), 64'd0);
    chk("b2b_rate", 64'(popc[popc.size()-1] - popc[popc.size()-4]), 64'd3);
    e0 = err_seen;
    send(32'h12345678, 0, argb, 6, w);
    repeat (4) @(negedge clk);
    chk("err_pulse6", 64'(err_seen - e0), 64'd1);
    chk("err_idle", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    send(32'h12345678, 0, argb, 7, w);
    repeat (4) @(negedge clk);
    chk("err_pulse7", 64'(err_seen - e0), 64'd2);
    @(posedge clk);
    #1 bus.out_ready = 0;
    send(32'h44332211, 0, pal, 3, w);
    repeat (3) @(negedge clk);
    chk("rst_pre_valid", 64'(bus.out_valid), 64'd1);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 bus.out_ready = 1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_resume", 64'(bus.out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    exp(32'hFF00FF00, 0); exp(32'hFFFF0000, 1);
    send(32'hF800_07E0, 0, rgb565, 4, w);
    drain("post_rst_drain");
    bus0.in_valid = 1; bus0.in_data = 32'h0000FFFF; bus0.in_count = 1; bus0.in_fmt = rgb565; bus0.in_bpp_log = 4;
    @(negedge clk);
    chk("rep0_in_ready", 64'(bus0.in_ready), 64'd1);
    @(posedge clk);
    #1 bus0.in_valid = 0;
    t = 0;
    @(negedge clk);
    while (!bus0.out_valid && t < 20) begin
      t++;
      @(negedge clk);
    end
    chk("rep0_col", 64'({bus0.out_valid, bus0.out_last, bus0.out_col}), 64'h3_FFF8FCF8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
